pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 101 ++++++++++
 tb/tb_pipe_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: decode/EX/WB pipeline control with illegal-opcode detection and WB-to-EX forwarding
// Ports: clk, rst (sync, active-high); decode inputs in_valid, opcode, rd, rs1, rs2, stall, flush;
// in_ready; ID/EX controls ex_*; EX/WB controls wb_*; fwd_a/fwd_b forwarding selects; illegal pulse.
// Optional PIPE_CTRL_PERF_EN adds 32-bit retired_cnt and illegal_cnt.
module pipe_ctrl #(
  parameter int OPW  = 2,
  parameter int REGW = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [OPW-1:0]  opcode,
  input  logic [REGW-1:0] rd,
  input  logic [REGW-1:0] rs1,
  input  logic [REGW-1:0] rs2,
  input  logic            stall,
  input  logic            flush,
  output logic            in_ready,
  output logic            ex_valid,
  output logic            ex_alu_sel,
  output logic            ex_alusrc,
  output logic            ex_regwrite,
  output logic [REGW-1:0] ex_rd,
  output logic            wb_valid,
  output logic            wb_regwrite,
  output logic [REGW-1:0] wb_rd,
  output logic            fwd_a,
  output logic            fwd_b,
  output logic            illegal
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]     retired_cnt,
  output logic [31:0]     illegal_cnt
`endif
);
  logic            r_ex_valid, r_ex_alu_sel, r_ex_alusrc, r_ex_regwrite, r_illegal;
  logic [REGW-1:0] r_ex_rd, r_ex_rs1, r_ex_rs2;
  logic            r_wb_valid, r_wb_regwrite;
  logic [REGW-1:0] r_wb_rd;
  logic            w_legal, w_sel, w_rw, w_accept, w_load;
  always_comb begin
    w_legal  = ((opcode >> 2) == '0) & (opcode[1:0] != 2'b10);
    w_sel    = opcode[1:0] == 2'b01;
    w_rw     = opcode[1:0] != 2'b11;
    w_accept = in_valid & ~stall & ~flush;
    w_load   = w_accept & w_legal;
  end
  always_ff @(posedge clk) begin
    if (rst | flush) begin
      r_ex_valid    <= 1'b0;
      r_ex_alu_sel  <= 1'b0;
      r_ex_alusrc   <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_rd       <= '0;
      r_ex_rs1      <= '0;
      r_ex_rs2      <= '0;
      r_illegal     <= 1'b0;
      r_wb_valid    <= 1'b0;
      r_wb_regwrite <= 1'b0;
      r_wb_rd       <= '0;
    end else begin
      r_ex_valid    <= w_load;
      r_ex_alu_sel  <= w_load & w_sel;
      r_ex_alusrc   <= w_load & w_sel;
      r_ex_regwrite <= w_load & w_rw;
      r_ex_rd       <= w_load ? rd : '0;
      r_ex_rs1      <= w_load ? rs1 : '0;
      r_ex_rs2      <= w_load ? rs2 : '0;
      r_illegal     <= w_accept & ~w_legal;
      r_wb_valid    <= r_ex_valid;
      r_wb_regwrite <= r_ex_regwrite & r_ex_valid;
      r_wb_rd       <= r_ex_rd;
    end
  end
  assign in_ready    = ~stall & ~flush;
  assign ex_valid    = r_ex_valid;
  assign ex_alu_sel  = r_ex_alu_sel;
  assign ex_alusrc   = r_ex_alusrc;
  assign ex_regwrite = r_ex_regwrite;
  assign ex_rd       = r_ex_rd;
  assign wb_valid    = r_wb_valid;
  assign wb_regwrite = r_wb_regwrite;
  assign wb_rd       = r_wb_rd;
  assign illegal     = r_illegal;
  assign fwd_a       = r_wb_valid & r_wb_regwrite & r_ex_valid & (r_wb_rd == r_ex_rs1);
  assign fwd_b       = r_wb_valid & r_wb_regwrite & r_ex_valid & (r_wb_rd == r_ex_rs2);
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_retired_cnt, r_illegal_cnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired_cnt <= '0;
      r_illegal_cnt <= '0;
    end else begin
      r_retired_cnt <= r_retired_cnt + {31'd0, r_wb_valid};
      r_illegal_cnt <= r_illegal_cnt + {31'd0, r_illegal};
    end
  end
  assign retired_cnt = r_retired_cnt;
  assign illegal_cnt = r_illegal_cnt;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: table-driven bench for pipe_ctrl plus an OPW=4 instance for wide-opcode decode
module tb_pipe_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, in_valid, stall, flush;
  logic [1:0] opcode, rd, rs1, rs2;
  logic in_ready, ex_valid, ex_alu_sel, ex_alusrc, ex_regwrite, wb_valid, wb_regwrite, fwd_a, fwd_b, illegal;
  logic [1:0] ex_rd, wb_rd;
  logic v4;
  logic [3:0] op4;
  logic [1:0] z2;
  logic z1;
  logic rdy4, exv4, sel4, src4, rw4, wbv4, wbrw4, fa4, fb4, ill4;
  logic [1:0] exrd4, wbrd4;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] retired_cnt, illegal_cnt, ret4, ill_c4;
`endif
  int errors = 0;
  int checks = 0;
  pipe_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .stall(stall), .flush(flush), .in_ready(in_ready), .ex_valid(ex_valid), .ex_alu_sel(ex_alu_sel),
    .ex_alusrc(ex_alusrc), .ex_regwrite(ex_regwrite), .ex_rd(ex_rd), .wb_valid(wb_valid),
    .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .fwd_a(fwd_a), .fwd_b(fwd_b), .illegal(illegal)
`ifdef PIPE_CTRL_PERF_EN
    , .retired_cnt(retired_cnt), .illegal_cnt(illegal_cnt)
`endif
  );
  pipe_ctrl #(.OPW(4), .REGW(2)) u4 (
    .clk(clk), .rst(rst), .in_valid(v4), .opcode(op4), .rd(z2), .rs1(z2), .rs2(z2),
    .stall(z1), .flush(z1), .in_ready(rdy4), .ex_valid(exv4), .ex_alu_sel(sel4),
    .ex_alusrc(src4), .ex_regwrite(rw4), .ex_rd(exrd4), .wb_valid(wbv4),
    .wb_regwrite(wbrw4), .wb_rd(wbrd4), .fwd_a(fa4), .fwd_b(fb4), .illegal(ill4)
`ifdef PIPE_CTRL_PERF_EN
    , .retired_cnt(ret4), .illegal_cnt(ill_c4)
`endif
  );
  typedef struct packed {
    logic [3:0] ctl;
    logic [1:0] op;
    logic [5:0] regs;
    logic       rdy;
    logic [3:0] ex;
    logic [1:0] exrd;
    logic [1:0] wb;
    logic [1:0] wbrd;
    logic [1:0] fwd;
    logic       ill;
  } vec_t;
  function automatic vec_t mk(input logic [3:0] ctl, input logic [1:0] op, input logic [5:0] regs,
                              input logic rdy, input logic [3:0] ex, input logic [1:0] exrd,
                              input logic [1:0] wb, input logic [1:0] wbrd, input logic [1:0] fwd,
                              input logic ill);
    return '{ctl, op, regs, rdy, ex, exrd, wb, wbrd, fwd, ill};
  endfunction
  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row=%0d got=%0h expected=%0h", name, row, act, exp);
    end
  endtask
  vec_t tv[18];
  initial begin
    tv[0]  = mk(4'b1000, 2'b00, 6'b00_00_00, 1'b1, 4'b0000, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[1]  = mk(4'b0100, 2'b00, 6'b01_00_00, 1'b1, 4'b1001, 2'd1, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[2]  = mk(4'b0100, 2'b00, 6'b10_00_00, 1'b1, 4'b1001, 2'd2, 2'b11, 2'd1, 2'b00, 1'b0);
    tv[3]  = mk(4'b0100, 2'b01, 6'b11_10_00, 1'b1, 4'b1111, 2'd3, 2'b11, 2'd2, 2'b10, 1'b0);
    tv[4]  = mk(4'b0100, 2'b11, 6'b00_00_11, 1'b1, 4'b1000, 2'd0, 2'b11, 2'd3, 2'b01, 1'b0);
    tv[5]  = mk(4'b0100, 2'b10, 6'b01_00_00, 1'b1, 4'b0000, 2'd0, 2'b10, 2'd0, 2'b00, 1'b1);
    tv[6]  = mk(4'b0100, 2'b00, 6'b01_00_00, 1'b1, 4'b1001, 2'd1, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[7]  = mk(4'b0110, 2'b00, 6'b10_00_00, 1'b0, 4'b0000, 2'd0, 2'b11, 2'd1, 2'b00, 1'b0);
    tv[8]  = mk(4'b0110, 2'b00, 6'b10_00_00, 1'b0, 4'b0000, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[9]  = mk(4'b0100, 2'b00, 6'b10_00_00, 1'b1, 4'b1001, 2'd2, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[10] = mk(4'b0111, 2'b01, 6'b01_10_10, 1'b0, 4'b0000, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[11] = mk(4'b0110, 2'b10, 6'b00_00_00, 1'b0, 4'b0000, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[12] = mk(4'b0100, 2'b00, 6'b11_00_00, 1'b1, 4'b1001, 2'd3, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[13] = mk(4'b0100, 2'b01, 6'b01_11_11, 1'b1, 4'b1111, 2'd1, 2'b11, 2'd3, 2'b11, 1'b0);
    tv[14] = mk(4'b1110, 2'b00, 6'b10_00_00, 1'b0, 4'b0000, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[15] = mk(4'b0100, 2'b00, 6'b10_00_00, 1'b1, 4'b1001, 2'd2, 2'b00, 2'd0, 2'b00, 1'b0);
    tv[16] = mk(4'b0100, 2'b01, 6'b00_01_10, 1'b1, 4'b1111, 2'd0, 2'b11, 2'd2, 2'b01, 1'b0);
    tv[17] = mk(4'b0001, 2'b00, 6'b00_00_00, 1'b0, 4'b0000, 2'd0, 2'b00, 2'd0, 2'b00, 1'b0);
    {rst, in_valid, stall, flush, opcode, rd, rs1, rs2} = '0;
    v4 = 1'b0; op4 = 4'd0; z2 = 2'd0; z1 = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 18; i++) begin
      {rst, in_valid, stall, flush} = tv[i].ctl;
      opcode = tv[i].op;
      {rd, rs1, rs2} = tv[i].regs;
      #1;
      chk("in_ready", i, {31'd0, in_ready}, {31'd0, tv[i].rdy});
      @(posedge clk);
      #1;
      chk("ex_ctl", i, {28'd0, ex_valid, ex_alu_sel, ex_alusrc, ex_regwrite}, {28'd0, tv[i].ex});
      chk("ex_rd", i, {30'd0, ex_rd}, {30'd0, tv[i].exrd});
      chk("wb_ctl", i, {30'd0, wb_valid, wb_regwrite}, {30'd0, tv[i].wb});
      chk("wb_rd", i, {30'd0, wb_rd}, {30'd0, tv[i].wbrd});
      chk("fwd", i, {30'd0, fwd_a, fwd_b}, {30'd0, tv[i].fwd});
      chk("illegal", i, {31'd0, illegal}, {31'd0, tv[i].ill});
      @(negedge clk);
    end
    {rst, in_valid, stall, flush} = 4'b0000;
    v4 = 1'b1; op4 = 4'b0101;
    @(posedge clk); #1;
    chk("w4_illegal", 100, {31'd0, ill4}, 32'd1);
    chk("w4_ex_valid", 100, {31'd0, exv4}, 32'd0);
    @(negedge clk);
    op4 = 4'b0001;
    @(posedge clk); #1;
    chk("w4_illegal", 101, {31'd0, ill4}, 32'd0);
    chk("w4_ex_ctl", 101, {28'd0, exv4, sel4, src4, rw4}, 32'hF);
    @(negedge clk);
    op4 = 4'b1000;
    @(posedge clk); #1;
    chk("w4_illegal", 102, {31'd0, ill4}, 32'd1);
    @(negedge clk);
    v4 = 1'b0;
`ifdef PIPE_CTRL_PERF_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("retired_rst", 200, retired_cnt, 32'd0);
    chk("illegal_cnt_rst", 200, illegal_cnt, 32'd0);
    in_valid = 1'b1; opcode = 2'b00; {rd, rs1, rs2} = 6'd0;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("retired_5", 201, retired_cnt, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("retired_clr", 202, retired_cnt, 32'd0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
